// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types, constants and helpers for the alu_cc execute
//                stage (operation codes, MUL sequencer states, imm5 extend).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_AND  = 3'b001,
        ALU_NOT  = 3'b010,
        ALU_PASS = 3'b011,
        ALU_MUL  = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mul_state_t;

    // Sign-extend the 5-bit immediate field of the instruction to a word
    function automatic logic [WORD_W-1:0] sext5(input logic [4:0] imm);
        return {{(WORD_W-5){imm[4]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Iterative shift-add multiplier. Latches A/B on Start, runs
//                MUL_CYCLES iterations, then presents the low word of the
//                product on PRODUCT with a one-cycle Done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] PRODUCT
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_sum;

    // Accumulator plus the current partial product (only low word is kept)
    assign acc_sum = acc_q + (b_q[0] ? a_q : '0);

    // Next-state and datapath update for the shift-add sequencer
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    prod_d  = acc_sum;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any multiply in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign Busy    = (state_q == S_RUN);
    assign Done    = (state_q == S_DONE);
    assign PRODUCT = prod_q;

endmodule
`default_nettype wire

// File: rtl/alu_cc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cc
//  Description : Execute stage: operand-B mux, combinational ADD/AND/NOT/PASS,
//                iterative MUL, NZP condition codes and the BEN branch flag.
//                Optional macro ALU_OVF_EN adds the registered overflow flag V.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cc
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  SR1_OUT,
    input  logic [WIDTH-1:0]  SR2_OUT,
    input  logic [WORD_W-1:0] IR,
    input  logic              SR2MUX,
    input  logic [2:0]        ALUK,
    input  logic              Start,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic [WIDTH-1:0]  BUS,
    output logic [WIDTH-1:0]  ALU_OUT,
    output logic              Busy,
    output logic              Done,
    output logic              N,
    output logic              Z,
    output logic              P,
`ifdef ALU_OVF_EN
    output logic              V,
`endif
    output logic              BEN
);

    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] product;
    logic             mul_start;
    logic             n_q, z_q, p_q, ben_q;
    logic             unused_ir;

    // Only imm5 and the nzp mask are consumed here
    assign unused_ir = ^{IR[15:12], IR[8:5]};

    assign b_op      = SR2MUX ? WIDTH'(signed'(sext5(IR[4:0]))) : SR2_OUT;
    assign sum       = SR1_OUT + b_op;
    assign mul_start = Start && (ALUK == ALU_MUL);

    alu_mul_seq #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (mul_start),
        .A       (SR1_OUT),
        .B       (b_op),
        .Busy    (Busy),
        .Done    (Done),
        .PRODUCT (product)
    );

    // Result select; reserved operation codes drive zero
    always_comb begin
        ALU_OUT = '0;
        case (ALUK)
            ALU_ADD:  ALU_OUT = sum;
            ALU_AND:  ALU_OUT = SR1_OUT & b_op;
            ALU_NOT:  ALU_OUT = ~SR1_OUT;
            ALU_PASS: ALU_OUT = SR1_OUT;
            ALU_MUL:  ALU_OUT = product;
            default:  ALU_OUT = '0;
        endcase
    end

    // Condition codes and branch enable; BEN sees the NZP value before this edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            n_q   <= 1'b0;
            z_q   <= 1'b1;
            p_q   <= 1'b0;
            ben_q <= 1'b0;
        end else begin
            if (LD_CC) begin
                n_q <= BUS[WIDTH-1];
                z_q <= (BUS == '0);
                p_q <= !BUS[WIDTH-1] && (BUS != '0);
            end
            if (LD_BEN) begin
                ben_q <= (IR[11] & n_q) | (IR[10] & z_q) | (IR[9] & p_q);
            end
        end
    end

    assign N   = n_q;
    assign Z   = z_q;
    assign P   = p_q;
    assign BEN = ben_q;

`ifdef ALU_OVF_EN
    logic v_q;
    logic add_ovf;

    // Signed overflow of the ADD currently on the combinational path
    assign add_ovf = (ALUK == ALU_ADD) && (SR1_OUT[WIDTH-1] == b_op[WIDTH-1])
                     && (sum[WIDTH-1] != SR1_OUT[WIDTH-1]);

    // Overflow flag captured alongside the condition codes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            v_q <= 1'b0;
        end else if (LD_CC) begin
            v_q <= add_ovf;
        end
    end

    assign V = v_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cc
//  Description : Self-checking bench for alu_cc with a behavioural reference
//                model (integer arithmetic). Covers ALU_OVF_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cc;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] SR1_OUT, SR2_OUT, IR, BUS;
    logic        SR2MUX, Start, LD_CC, LD_BEN;
    logic [2:0]  ALUK;
    logic [15:0] ALU_OUT;
    logic        Busy, Done, N, Z, P, BEN;
`ifdef ALU_OVF_EN
    logic        V;
`endif

    int vectors = 0;
    int errors  = 0;

    // Reference state
    logic [15:0] exp_prod;
    logic        m_n, m_z, m_p, m_ben, m_v;

    alu_cc dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .SR1_OUT (SR1_OUT),
        .SR2_OUT (SR2_OUT),
        .IR      (IR),
        .SR2MUX  (SR2MUX),
        .ALUK    (ALUK),
        .Start   (Start),
        .LD_CC   (LD_CC),
        .LD_BEN  (LD_BEN),
        .BUS     (BUS),
        .ALU_OUT (ALU_OUT),
        .Busy    (Busy),
        .Done    (Done),
        .N       (N),
        .Z       (Z),
        .P       (P),
`ifdef ALU_OVF_EN
        .V       (V),
`endif
        .BEN     (BEN)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Operand B as the instruction set defines it
    function automatic logic [15:0] ref_b(input logic mux, input logic [15:0] sr2, input logic [15:0] ir);
        int imm;
        imm = int'(ir[4:0]);
        if (imm >= 16) imm = imm - 32;
        return mux ? 16'(imm) : sr2;
    endfunction

    function automatic logic [15:0] ref_alu(input logic [2:0] k, input logic [15:0] a, input logic [15:0] b);
        case (k)
            3'd0:    return 16'((int'(a) + int'(b)) % 65536);
            3'd1:    return a & b;
            3'd2:    return 16'hFFFF - a;
            3'd3:    return a;
            3'd4:    return exp_prod;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] k, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, s;
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        s  = sa + sb;
        return (k == 3'd0) && (s > 32767 || s < -32768);
    endfunction

    task automatic model_reset();
        m_n = 1'b0; m_z = 1'b1; m_p = 1'b0; m_ben = 1'b0; m_v = 1'b0;
        exp_prod = 16'h0000;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        model_reset();
        ALUK = 3'b100;
        #1;
        vectors++;
        if ({N, Z, P, BEN} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_cc: got NZP/BEN=%b want 0100", {N, Z, P, BEN});
        end
        vectors++;
        if ({Busy, Done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy: got Busy/Done=%b want 00", {Busy, Done});
        end
        vectors++;
        if (ALU_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL reset_prod: got %h want 0000", ALU_OUT);
        end
`ifdef ALU_OVF_EN
        vectors++;
        if (V !== 1'b0) begin
            errors++;
            $display("FAIL reset_v: got %b want 0", V);
        end
`endif
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_comb();
        logic [15:0] exp;
        // Directed: imm5 = -3, AND with register, NOT
        SR1_OUT = 16'h0005; IR = 16'h001D; SR2MUX = 1'b1; ALUK = 3'b000; SR2_OUT = 16'h00FF;
        #1;
        vectors++;
        if (ALU_OUT !== 16'h0002) begin
            errors++;
            $display("FAIL add_imm: got %h want 0002", ALU_OUT);
        end
        SR2MUX = 1'b0; ALUK = 3'b001;
        #1;
        vectors++;
        if (ALU_OUT !== 16'h0005) begin
            errors++;
            $display("FAIL and_reg: got %h want 0005", ALU_OUT);
        end
        ALUK = 3'b010;
        #1;
        vectors++;
        if (ALU_OUT !== 16'hFFFA) begin
            errors++;
            $display("FAIL not_a: got %h want FFFA", ALU_OUT);
        end
        // Random operands over every operation code, including reserved ones
        for (int i = 0; i < 60; i++) begin
            SR1_OUT = 16'($urandom);
            SR2_OUT = 16'($urandom);
            IR      = 16'($urandom);
            SR2MUX  = 1'($urandom);
            ALUK    = 3'($urandom_range(0, 7));
            #1;
            exp = ref_alu(ALUK, SR1_OUT, ref_b(SR2MUX, SR2_OUT, IR));
            vectors++;
            if (ALU_OUT !== exp) begin
                errors++;
                $display("FAIL comb_rand k=%0d a=%h: got %h want %h", ALUK, SR1_OUT, ALU_OUT, exp);
            end
        end
    endtask

    task automatic do_mul(input logic [15:0] a, input logic [15:0] sr2, input logic [15:0] ir, input logic mux);
        int n;
        logic [15:0] b;
        b = ref_b(mux, sr2, ir);
        SR1_OUT = a; SR2_OUT = sr2; IR = ir; SR2MUX = mux; ALUK = 3'b100;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            if (n == 5) begin
                // A second request and new operands mid-run must be ignored
                SR1_OUT = 16'($urandom); SR2_OUT = 16'($urandom);
                Start = 1'b1;
            end
            tick();
            Start = 1'b0;
        end
        exp_prod = 16'((longint'(a) * longint'(b)) % 65536);
        vectors++;
        if (n != 16) begin
            errors++;
            $display("FAIL mul_busy_len: got %0d cycles want 16", n);
        end
        vectors++;
        if (Done !== 1'b1 || ALU_OUT !== exp_prod) begin
            errors++;
            $display("FAIL mul_done a=%h b=%h: got Done=%b out=%h want Done=1 out=%h", a, b, Done, ALU_OUT, exp_prod);
        end
        Start = 1'b1;  // request while Done must be ignored
        tick();
        Start = 1'b0;
        vectors++;
        if (Done !== 1'b0 || Busy !== 1'b0 || ALU_OUT !== exp_prod) begin
            errors++;
            $display("FAIL mul_after: got Done=%b Busy=%b out=%h want 0 0 %h", Done, Busy, ALU_OUT, exp_prod);
        end
        tick();
        vectors++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_restart: got Busy=%b want 0", Busy);
        end
    endtask

    task automatic test_mul();
        logic [15:0] a, s, ir;
        do_mul(16'h0007, 16'h0009, 16'h0000, 1'b0);
        do_mul(16'hFFFF, 16'h0002, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a  = 16'($urandom);
            s  = 16'($urandom);
            ir = 16'($urandom);
            do_mul(a, s, ir, 1'($urandom));
        end
    endtask

    task automatic test_mul_reset();
        int dones;
        SR1_OUT = 16'h1234; SR2_OUT = 16'h0055; SR2MUX = 1'b0; ALUK = 3'b100;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_reset();
        vectors++;
        if (Busy !== 1'b0 || Done !== 1'b0 || ALU_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL mul_reset: got Busy=%b Done=%b out=%h want 0 0 0000", Busy, Done, ALU_OUT);
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done === 1'b1 || Busy === 1'b1) dones++;
            tick();
        end
        vectors++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mul_reset_quiet: got %0d active cycles want 0", dones);
        end
    endtask

    task automatic test_cc();
        logic [15:0] buses [3];
        logic [2:0]  want  [3];
        logic        nb;
        buses[0] = 16'h8000; buses[1] = 16'h0000; buses[2] = 16'h1234;
        want[0]  = 3'b100;   want[1]  = 3'b010;   want[2]  = 3'b001;
        ALUK = 3'b011; LD_BEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            BUS = buses[i]; LD_CC = 1'b1;
            tick();
            LD_CC = 1'b0;
            vectors++;
            if ({N, Z, P} !== want[i]) begin
                errors++;
                $display("FAIL cc_dir bus=%h: got NZP=%b want %b", buses[i], {N, Z, P}, want[i]);
            end
        end
        m_n = 1'b0; m_z = 1'b0; m_p = 1'b1;
        IR = 16'h0200; LD_BEN = 1'b1;
        tick();
        vectors++;
        if (BEN !== 1'b1) begin
            errors++;
            $display("FAIL ben_p: got %b want 1", BEN);
        end
        IR = 16'h0C00;
        tick();
        LD_BEN = 1'b0;
        m_ben = 1'b0;
        vectors++;
        if (BEN !== 1'b0) begin
            errors++;
            $display("FAIL ben_nz: got %b want 0", BEN);
        end
        // Random interleaving of LD_CC / LD_BEN; BEN uses the pre-update codes
        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 3))
                0:       BUS = 16'h0000;
                1:       BUS = 16'h8000 | 16'($urandom);
                default: BUS = 16'($urandom);
            endcase
            IR = 16'($urandom); SR1_OUT = 16'($urandom); SR2_OUT = 16'($urandom);
            SR2MUX = 1'($urandom); ALUK = 3'($urandom_range(0, 3));
            LD_CC = 1'($urandom); LD_BEN = 1'($urandom);
            #1;
            nb = (IR[11] & m_n) | (IR[10] & m_z) | (IR[9] & m_p);
            if (LD_BEN) m_ben = nb;
            if (LD_CC) begin
                m_v = ref_ovf(ALUK, SR1_OUT, ref_b(SR2MUX, SR2_OUT, IR));
                m_n = (BUS >= 16'h8000);
                m_z = (BUS == 16'h0000);
                m_p = (BUS != 16'h0000) && (BUS < 16'h8000);
            end
            tick();
            LD_CC = 1'b0; LD_BEN = 1'b0;
            vectors++;
            if ({N, Z, P, BEN} !== {m_n, m_z, m_p, m_ben}) begin
                errors++;
                $display("FAIL cc_rand bus=%h ir=%h: got NZP/BEN=%b want %b", BUS, IR, {N, Z, P, BEN}, {m_n, m_z, m_p, m_ben});
            end
`ifdef ALU_OVF_EN
            vectors++;
            if (V !== m_v) begin
                errors++;
                $display("FAIL v_rand: got %b want %b", V, m_v);
            end
`endif
        end
    endtask

`ifdef ALU_OVF_EN
    task automatic test_ovf();
        SR2MUX = 1'b0; ALUK = 3'b000; LD_BEN = 1'b0; BUS = 16'h0001;
        SR1_OUT = 16'h7FFF; SR2_OUT = 16'h0001; LD_CC = 1'b1;
        tick();
        vectors++;
        if (V !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: got %b want 1", V);
        end
        SR1_OUT = 16'h0001; SR2_OUT = 16'h0001;
        tick();
        vectors++;
        if (V !== 1'b0) begin
            errors++;
            $display("FAIL ovf_none: got %b want 0", V);
        end
        SR1_OUT = 16'h7FFF; ALUK = 3'b011;
        tick();
        LD_CC = 1'b0;
        vectors++;
        if (V !== 1'b0) begin
            errors++;
            $display("FAIL ovf_nonadd: got %b want 0", V);
        end
    endtask
`endif

    initial begin
        Reset = 1'b1; SR1_OUT = '0; SR2_OUT = '0; IR = '0; BUS = '0;
        SR2MUX = 1'b0; ALUK = 3'b000; Start = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0;
        model_reset();
        test_reset();
        test_comb();
        test_mul();
        test_mul_reset();
        test_cc();
`ifdef ALU_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
